// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: M-extension funct3 encodings, the multiply/divide
// unit state type and small decode helpers for the operand sign modes.
package riscv_pkg;

    // RV32M funct3 encodings
    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM
    function automatic logic op_a_is_signed(input logic [2:0] f);
        return (f == MUL) || (f == MULH) || (f == MULHSU) || (f == DIV) || (f == REM);
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV and REM
    function automatic logic op_b_is_signed(input logic [2:0] f);
        return (f == MUL) || (f == MULH) || (f == DIV) || (f == REM);
    endfunction

endpackage

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit. One shared 2*XLEN shift register and
// one XLEN+1 bit adder/subtractor handle both shift-add multiplication and
// restoring division on operand magnitudes, one bit per cycle; the sign is
// applied when the final value is written to result. Divide-by-zero and
// signed overflow bypass the iteration and go straight to DONE.
module mdu_iterative
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t        state_reg;
    logic [2*XLEN-1:0] shift_reg;
    logic [XLEN-1:0]   b_mag_reg;
    logic [CW-1:0]     cnt_reg;
    logic [2:0]        funct3_reg;
    logic              neg_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [XLEN-1:0]   result_reg;

    // Operand decode at accept time
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic            neg_next;
    logic [XLEN-1:0] special_result;

    // Shared iteration datapath
    logic [XLEN-1:0]   hi, lo;
    logic              is_div_op;
    logic [XLEN:0]     add_x, add_y, add_sum;
    logic [2*XLEN-1:0] shift_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_sel, div_fix;
    logic [XLEN-1:0]   final_result;

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

    // Decode signs, magnitudes and the two divide shortcuts from the live operands
    always_comb begin
        a_neg    = op_a_is_signed(funct3) && op_a[XLEN-1];
        b_neg    = op_b_is_signed(funct3) && op_b[XLEN-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        div_zero = (op_b == '0);
        div_ovf  = ((funct3 == DIV) || (funct3 == REM)) && (op_a == MIN_NEG) && (op_b == '1);
        special  = funct3[2] && (div_zero || div_ovf);
        // remainder follows the dividend; product and quotient follow the sign XOR
        neg_next = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
        if (funct3[1]) begin
            special_result = div_zero ? op_a : '0;
        end else begin
            special_result = div_zero ? '1 : op_a;
        end
    end

    // One multiply or divide step on the shared shift register and adder
    always_comb begin
        hi        = shift_reg[2*XLEN-1:XLEN];
        lo        = shift_reg[XLEN-1:0];
        is_div_op = funct3_reg[2];
        // divide tests the remainder shifted left by one; multiply adds to the high half
        add_x     = is_div_op ? {hi, lo[XLEN-1]} : {1'b0, hi};
        add_y     = {1'b0, b_mag_reg};
        add_sum   = is_div_op ? (add_x - add_y) : (add_x + add_y);
        if (is_div_op) begin
            // bit XLEN set means the trial subtraction borrowed: restore
            if (!add_sum[XLEN]) begin
                shift_next = {add_sum[XLEN-1:0], lo[XLEN-2:0], 1'b1};
            end else begin
                shift_next = {shift_reg[2*XLEN-2:0], 1'b0};
            end
        end else begin
            if (lo[0]) begin
                shift_next = {add_sum, lo[XLEN-1:1]};
            end else begin
                shift_next = {1'b0, hi, lo[XLEN-1:1]};
            end
        end
    end

    // Apply the sign and select the output half from the final step's value
    always_comb begin
        prod_fix = neg_reg ? -shift_next : shift_next;
        div_sel  = funct3_reg[1] ? shift_next[2*XLEN-1:XLEN] : shift_next[XLEN-1:0];
        div_fix  = neg_reg ? -div_sel : div_sel;
        if (funct3_reg[2]) begin
            final_result = div_fix;
        end else if (funct3_reg == MUL) begin
            final_result = prod_fix[XLEN-1:0];
        end else begin
            final_result = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // Control FSM with registered busy/done/result and operand capture on accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            b_mag_reg  <= '0;
            cnt_reg    <= '0;
            funct3_reg <= '0;
            neg_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        funct3_reg <= funct3;
                        neg_reg    <= neg_next;
                        b_mag_reg  <= b_mag;
                        shift_reg  <= {{XLEN{1'b0}}, a_mag};
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        if (special) begin
                            result_reg <= special_result;
                            done_reg   <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            state_reg  <= CALC;
                        end
                    end
                end
                CALC: begin
                    shift_reg <= shift_next;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST_CNT) begin
                        result_reg <= final_result;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed RV32M cases, divide
// shortcuts, busy/start interaction, mid-operation reset and random ops,
// with expected results queued at launch and compared on each done pulse.
module tb_mdu_iterative;
    import riscv_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [2:0]      funct3 = 3'b000;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expv;
    } txn_t;

    txn_t exp_q[$];
    txn_t mon_t;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done = 0;

    mdu_iterative #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, expv);
        end
    endtask

    // Reference model written directly from the RV32M definitions
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub_s, p;
        logic [63:0]        up;
        logic signed [31:0] a32, b32, q32;
        logic [31:0]        r;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ub_s = {32'b0, b};
        a32  = a;
        b32  = b;
        r    = '0;
        case (f)
            MUL:    begin p = sa * sb;   r = p[31:0];  end
            MULH:   begin p = sa * sb;   r = p[63:32]; end
            MULHSU: begin p = sa * ub_s; r = p[63:32]; end
            MULHU:  begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
            DIV: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else begin q32 = a32 / b32; r = q32; end
            end
            DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                else begin q32 = a32 % b32; r = q32; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Compare every done pulse against the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_t = exp_q.pop_front();
                $display("txn funct3=%0d a=%h b=%h result=%h expected=%h",
                         mon_t.f, mon_t.a, mon_t.b, result, mon_t.expv);
                check_val($sformatf("result_f%0d_%h_%h", mon_t.f, mon_t.a, mon_t.b), result, mon_t.expv);
            end
        end
    end

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
        int   lat;
        bit   seen;
        logic [31:0] expv;
        expv = ref_model(f, a, b);
        @(posedge clk); #1;
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        exp_q.push_back('{f, a, b, expv});
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (i == 1) check_val({tag, "_busy"}, {31'b0, busy}, 32'd1);
            if (done) begin
                lat  = i;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_val({tag, "_timeout"}, 32'd0, 32'd1);
        else check_val({tag, "_latency"}, 32'(lat), is_special(f, a, b) ? 32'd1 : 32'(XLEN + 1));
        @(posedge clk); #1;
        check_val({tag, "_done_drop"}, {31'b0, done}, 32'd0);
        check_val({tag, "_busy_drop"}, {31'b0, busy}, 32'd0);
        check_val({tag, "_hold"}, result, expv);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        // Reset state
        #1;
        check_val("reset_busy", {31'b0, busy}, 32'd0);
        check_val("reset_done", {31'b0, done}, 32'd0);
        check_val("reset_result", result, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Multiply sign modes
        run_op(MUL,    32'd7,         32'hFFFF_FFFD, "mul_7_m3");
        run_op(MULH,   32'h8000_0000, 32'h8000_0000, "mulh_min");
        run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones");
        run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones");

        // Division signs
        run_op(DIV,  32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(REM,  32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run_op(DIVU, 32'd100,       32'd7, "divu_100_7");
        run_op(REMU, 32'd100,       32'd7, "remu_100_7");

        // Divide shortcuts
        run_op(DIVU, 32'd5,         32'd0,         "divu_by0");
        run_op(REM,  32'd5,         32'd0,         "rem_by0");
        run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

        // Start held through busy with new operands, then back-to-back accept
        @(posedge clk); #1;
        funct3 = DIVU; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        exp_q.push_back('{DIVU, 32'd100, 32'd7, ref_model(DIVU, 32'd100, 32'd7)});
        @(posedge clk); #1;
        funct3 = MUL; op_a = 32'd6; op_b = 32'd7;
        exp_q.push_back('{MUL, 32'd6, 32'd7, ref_model(MUL, 32'd6, 32'd7)});
        wait_done("b2b_first");
        @(posedge clk); #1;
        check_val("b2b_idle_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check_val("b2b_accept_busy", {31'b0, busy}, 32'd1);
        wait_done("b2b_second");
        @(posedge clk); #1;

        // Reset mid-operation
        @(posedge clk); #1;
        funct3 = MUL; op_a = 32'd1234; op_b = 32'd5678; start = 1'b1;
        exp_q.push_back('{MUL, 32'd1234, 32'd5678, ref_model(MUL, 32'd1234, 32'd5678)});
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        void'(exp_q.pop_back());
        #1;
        check_val("abort_busy", {31'b0, busy}, 32'd0);
        check_val("abort_done", {31'b0, done}, 32'd0);
        check_val("abort_result", result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        d0 = n_done;
        repeat (40) @(posedge clk);
        #1;
        check_val("abort_no_done", 32'(n_done), 32'(d0));
        run_op(MUL, 32'd3, 32'd4, "mul_after_abort");

        // Random operations
        for (int i = 0; i < 24; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op(rf, ra, rb, $sformatf("rand%0d", i));
        end

        repeat (3) @(posedge clk);
        #1;
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
